// File: rtl/dibit_pixel_receiver_if.sv
// Dibit link plus frame-buffer write port of the pixel receiver.
interface dibit_pixel_receiver_if #(
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned PIXEL_WIDTH = 8
);
    logic                   axiiv;
    logic [1:0]             axiid;
    logic [PIXEL_WIDTH-1:0] pixel_out;
    logic [ADDR_WIDTH-1:0]  pixel_addr_out;
    logic                   pixel_valid;
    logic                   packet_done;
    logic                   frag_err;

    // Transmitter / stimulus side.
    modport master (
        output axiiv, axiid,
        input  pixel_out, pixel_addr_out, pixel_valid, packet_done, frag_err
    );

    // Receiver side.
    modport slave (
        input  axiiv, axiid,
        output pixel_out, pixel_addr_out, pixel_valid, packet_done, frag_err
    );
endinterface

// File: rtl/dibit_pixel_receiver.sv
// Reassembles an address + pixel packet from a 2-bit stream into BRAM writes.
module dibit_pixel_receiver #(
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned PIXEL_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dibit_pixel_receiver_if.slave bus
);
    localparam int unsigned ADDR_DIBITS = ADDR_WIDTH / 2;
    localparam int unsigned PIX_DIBITS  = PIXEL_WIDTH / 2;
    localparam int unsigned MAX_DIBITS  = (ADDR_DIBITS > PIX_DIBITS) ? ADDR_DIBITS : PIX_DIBITS;
    localparam int unsigned CNT_W       = $clog2(MAX_DIBITS + 1);
    localparam int unsigned ADDR_IW     = $clog2(ADDR_WIDTH);
    localparam int unsigned PIX_IW      = $clog2(PIXEL_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        PIXEL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_sh_q, addr_sh_d;
    logic [PIXEL_WIDTH-1:0] pix_sh_q, pix_sh_d;
    logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic                   written_q, written_d;
    // Completed pixel waits one cycle so its strobe lines up with the end-of-packet pulse.
    logic                   pend_q, pend_d;
    logic [PIXEL_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
    logic [PIXEL_WIDTH-1:0] pixel_out_q, pixel_out_d;
    logic [ADDR_WIDTH-1:0]  pixel_addr_q, pixel_addr_d;
    logic                   pixel_valid_q, pixel_valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_sh_q     <= '0;
            pix_sh_q      <= '0;
            cur_addr_q    <= '0;
            written_q     <= 1'b0;
            pend_q        <= 1'b0;
            pend_data_q   <= '0;
            pend_addr_q   <= '0;
            pixel_out_q   <= '0;
            pixel_addr_q  <= '0;
            pixel_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_sh_q     <= addr_sh_d;
            pix_sh_q      <= pix_sh_d;
            cur_addr_q    <= cur_addr_d;
            written_q     <= written_d;
            pend_q        <= pend_d;
            pend_data_q   <= pend_data_d;
            pend_addr_q   <= pend_addr_d;
            pixel_out_q   <= pixel_out_d;
            pixel_addr_q  <= pixel_addr_d;
            pixel_valid_q <= pixel_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Next-state, field assembly and output strobes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_sh_d     = addr_sh_q;
        pix_sh_d      = pix_sh_q;
        cur_addr_d    = cur_addr_q;
        written_d     = written_q;
        pend_d        = 1'b0;
        pend_data_d   = pend_data_q;
        pend_addr_d   = pend_addr_q;
        pixel_valid_d = pend_q;
        pixel_out_d   = pend_q ? pend_data_q : pixel_out_q;
        pixel_addr_d  = pend_q ? pend_addr_q : pixel_addr_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.axiiv) begin
                    addr_sh_d      = '0;
                    addr_sh_d[1:0] = bus.axiid;
                    cnt_d          = CNT_W'(1);
                    state_d        = ADDR;
                end
            end
            ADDR: begin
                if (!bus.axiiv) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    addr_sh_d[ADDR_IW'({cnt_q, 1'b0}) +: 2] = bus.axiid;
                    if (cnt_q == CNT_W'(ADDR_DIBITS - 1)) begin
                        cur_addr_d = addr_sh_d;
                        written_d  = 1'b0;
                        cnt_d      = '0;
                        state_d    = PIXEL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PIXEL: begin
                if (!bus.axiiv) begin
                    if ((cnt_q == '0) && written_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    pix_sh_d[PIX_IW'({cnt_q, 1'b0}) +: 2] = bus.axiid;
                    if (cnt_q == CNT_W'(PIX_DIBITS - 1)) begin
                        pend_d      = 1'b1;
                        pend_data_d = pix_sh_d;
                        pend_addr_d = cur_addr_q;
                        cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                        written_d   = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.pixel_out      = pixel_out_q;
    assign bus.pixel_addr_out = pixel_addr_q;
    assign bus.pixel_valid    = pixel_valid_q;
    assign bus.packet_done    = done_q;
    assign bus.frag_err       = err_q;
endmodule

// File: tb/tb_dibit_pixel_receiver.sv
// Directed bench for dibit_pixel_receiver with a packet-level expectation model.
module tb_dibit_pixel_receiver;
    localparam int unsigned AW   = 24;
    localparam int unsigned PW   = 8;
    localparam int          MAXC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dibit_pixel_receiver_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) bus ();

    dibit_pixel_receiver #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Expected outputs indexed by the clock edge after which they are visible.
    bit          exp_pv   [MAXC];
    bit          exp_done [MAXC];
    bit          exp_err  [MAXC];
    logic [7:0]  exp_pd   [MAXC];
    logic [23:0] exp_pa   [MAXC];

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  pix_tab [8];
    logic [23:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    int n_done = 0;
    int n_err  = 0;
    int pv_cyc = -1;
    int done_cyc = -1;

    logic [7:0]  mpix  = '0;
    logic [23:0] maddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        logic e_pv, e_done, e_err;
        e_pv = 1'b0; e_done = 1'b0; e_err = 1'b0;
        if (!rst) begin
            mpix  = '0;
            maddr = '0;
        end else if (cyc < MAXC) begin
            e_pv   = exp_pv[cyc];
            e_done = exp_done[cyc];
            e_err  = exp_err[cyc];
            if (e_pv) begin
                mpix  = exp_pd[cyc];
                maddr = exp_pa[cyc];
            end
        end
        nvec++;
        if ({bus.pixel_valid, bus.packet_done, bus.frag_err, bus.pixel_out, bus.pixel_addr_out}
            !== {e_pv, e_done, e_err, mpix, maddr}) begin
            nerr++;
            $display("FAIL cycle %0d outputs: got pv=%b done=%b err=%b pix=%h addr=%h, expected pv=%b done=%b err=%b pix=%h addr=%h",
                     cyc, bus.pixel_valid, bus.packet_done, bus.frag_err, bus.pixel_out, bus.pixel_addr_out,
                     e_pv, e_done, e_err, mpix, maddr);
        end
        if (bus.pixel_valid === 1'b1) begin
            wr_addr.push_back(bus.pixel_addr_out);
            wr_data.push_back(bus.pixel_out);
            pv_cyc = cyc;
        end
        if (bus.packet_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (bus.frag_err === 1'b1) n_err++;
    end

    task automatic drive(input logic v, input logic [1:0] d, output int e);
        @(negedge clk);
        bus.axiiv = v;
        bus.axiid = d;
        e = cyc + 1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom), e);
    endtask

    // Sends na address dibits, np whole pixels from pix_tab, nt dibits of pix_tab[np], then one idle.
    task automatic send_packet(input logic [23:0] a, input int na, input int np, input int nt, output int s);
        int e;
        logic [23:0] at;
        logic [7:0]  p, pt;
        s = -1;
        for (int k = 0; k < na; k++) begin
            at = a >> (2 * k);
            drive(1'b1, at[1:0], e);
            if (k == 0) s = e;
        end
        if (na == int'(AW / 2)) begin
            for (int i = 0; i < np; i++) begin
                p = pix_tab[i];
                for (int k = 0; k < int'(PW / 2); k++) begin
                    pt = p >> (2 * k);
                    drive(1'b1, pt[1:0], e);
                end
                exp_pv[e + 1] = 1'b1;
                exp_pd[e + 1] = p;
                exp_pa[e + 1] = a + 24'(i);
            end
            for (int k = 0; k < nt; k++) begin
                pt = pix_tab[np] >> (2 * k);
                drive(1'b1, pt[1:0], e);
            end
        end
        drive(1'b0, 2'($urandom), e);
        if ((na == int'(AW / 2)) && (np > 0) && (nt == 0)) exp_done[e] = 1'b1;
        else exp_err[e] = 1'b1;
    endtask

    initial begin
        int s, b, d0, e0, e;
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        #1;
        check("reset_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("reset_frag_err", 32'(bus.frag_err), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        idle(2);

        // Single pixel, strobe and done coincide.
        pix_tab[0] = 8'hE4;
        b = wr_addr.size(); d0 = n_done;
        send_packet(24'h000005, 12, 1, 0, s);
        idle(3);
        check("t1_writes", 32'(wr_addr.size() - b), 32'd1);
        check("t1_addr", 32'(wr_addr[b]), 32'h5);
        check("t1_data", 32'(wr_data[b]), 32'hE4);
        check("t1_pv_latency", 32'(pv_cyc - s), 32'd16);
        check("t1_done_latency", 32'(done_cyc - s), 32'd16);
        check("t1_done_count", 32'(n_done - d0), 32'd1);

        // Four back-to-back pixels.
        for (int i = 0; i < 4; i++) pix_tab[i] = 8'hE4;
        b = wr_addr.size(); d0 = n_done;
        send_packet(24'h000000, 12, 4, 0, s);
        idle(3);
        check("t2_writes", 32'(wr_addr.size() - b), 32'd4);
        check("t2_addr3", 32'(wr_addr[b + 3]), 32'h3);
        check("t2_data3", 32'(wr_data[b + 3]), 32'hE4);
        check("t2_done_count", 32'(n_done - d0), 32'd1);

        // Address wrap.
        pix_tab[0] = 8'h1B; pix_tab[1] = 8'hFF;
        b = wr_addr.size(); e0 = n_err;
        send_packet(24'hFFFFFF, 12, 2, 0, s);
        idle(3);
        check("t3_addr0", 32'(wr_addr[b]), 32'hFFFFFF);
        check("t3_addr1", 32'(wr_addr[b + 1]), 32'h0);
        check("t3_data1", 32'(wr_data[b + 1]), 32'hFF);
        check("t3_no_err", 32'(n_err - e0), 32'd0);

        // Truncated address, then a clean packet right after.
        b = wr_addr.size(); e0 = n_err;
        send_packet(24'h123456, 5, 0, 0, s);
        pix_tab[0] = 8'hAA;
        send_packet(24'h000010, 12, 1, 0, s);
        idle(3);
        check("t4_err", 32'(n_err - e0), 32'd1);
        check("t4_writes", 32'(wr_addr.size() - b), 32'd1);
        check("t4_addr", 32'(wr_addr[b]), 32'h10);
        check("t4_data", 32'(wr_data[b]), 32'hAA);

        // Partial second pixel.
        pix_tab[0] = 8'h3C; pix_tab[1] = 8'h99;
        b = wr_addr.size(); e0 = n_err; d0 = n_done;
        send_packet(24'h000040, 12, 1, 2, s);
        idle(3);
        check("t5_writes", 32'(wr_addr.size() - b), 32'd1);
        check("t5_err", 32'(n_err - e0), 32'd1);
        check("t5_no_done", 32'(n_done - d0), 32'd0);

        // Address only, no pixels.
        e0 = n_err;
        send_packet(24'h000080, 12, 0, 0, s);
        idle(3);
        check("t5b_err", 32'(n_err - e0), 32'd1);

        // Asynchronous reset mid-pixel.
        e0 = n_err; d0 = n_done; b = wr_addr.size();
        for (int k = 0; k < 12; k++) drive(1'b1, (k == 2) ? 2'b10 : 2'b00, e);
        drive(1'b1, 2'b11, e);
        drive(1'b1, 2'b01, e);
        @(posedge clk);
        #2 rst = 1'b0;
        bus.axiiv = 1'b0;
        #1;
        check("rst_pixel_out", 32'(bus.pixel_out), 32'h0);
        check("rst_addr_out", 32'(bus.pixel_addr_out), 32'h0);
        check("rst_pixel_valid", 32'(bus.pixel_valid), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        idle(2);
        check("rst_no_err", 32'(n_err - e0), 32'd0);
        check("rst_no_done", 32'(n_done - d0), 32'd0);

        // Fresh packet after reset.
        pix_tab[0] = 8'h5A;
        send_packet(24'h000007, 12, 1, 0, s);
        idle(3);
        check("t7_writes", 32'(wr_addr.size() - b), 32'd1);
        check("t7_addr", 32'(wr_addr[b]), 32'h7);
        check("t7_data", 32'(wr_data[b]), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dibit_pixel_receiver.md
Name: dibit_pixel_receiver

Overview:
Receive-side counterpart of the FPGA1 pixel transmitter. Consumes the 2-bit dibit stream (axiiv/axiid) carrying one packet: a start address followed by pixel bytes. Reassembles the bytes and emits pixel write strobes with incrementing addresses, for direct connection to the frame-buffer BRAM write port on the receiving FPGA.

Parameters:
ADDR_WIDTH, 24, pixel address width; must be even. Address field is ADDR_WIDTH/2 dibits.
PIXEL_WIDTH, 8, pixel width; must be even. One pixel is PIXEL_WIDTH/2 dibits.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-low reset
axiiv  input  1  dibit valid; high for the whole packet, low between packets
axiid  input  2  dibit data; qualified by axiiv
pixel_out  output  PIXEL_WIDTH  reassembled pixel
pixel_addr_out  output  ADDR_WIDTH  BRAM write address for pixel_out
pixel_valid  output  1  one-cycle write strobe for pixel_out/pixel_addr_out
packet_done  output  1  one-cycle pulse: packet ended cleanly
frag_err  output  1  one-cycle pulse: packet ended malformed

Behaviour:
- Reset (rst low, async): state=IDLE; all counters and shift registers 0; all outputs 0.
- Bit order: fields are sent LSB dibit first. The k-th dibit of a field (k from 0) carries bits [2k+1:2k], with axiid[1] as the higher bit. The address uses the same order.
- States and transitions:
  - IDLE: wait for axiiv=1. The first valid dibit is address dibit 0; move to ADDR with the dibit count at 1.
  - ADDR: shift in dibits while axiiv=1. After dibit ADDR_WIDTH/2-1, load the address register and go to PIXEL with the dibit count at 0.
  - PIXEL: shift in dibits. After dibit PIXEL_WIDTH/2-1, on the next cycle: pixel_out=assembled byte, pixel_addr_out=current address, pixel_valid=1. Then the current address increments by 1.
- Latency: pixel_valid rises exactly 1 cycle after the clock edge that samples the last dibit of a pixel. Back-to-back pixels produce a strobe every PIXEL_WIDTH/2 cycles.
- Output hold: pixel_out and pixel_addr_out hold their last values when pixel_valid=0.
- Address arithmetic: increments modulo 2^ADDR_WIDTH. 0xFFFFFF + 1 = 0x000000, with no error.
- axiiv low mid-packet ends the packet; return to IDLE on that cycle. axiid is ignored while axiiv=0.
  - In PIXEL with dibit count 0 and at least 1 pixel written: packet_done=1 for 1 cycle.
  - In ADDR (incomplete address), in PIXEL with a partial pixel, or in PIXEL with 0 pixels written: frag_err=1 for 1 cycle. Partial data is discarded; no pixel_valid.
- Simultaneous events: if the last dibit of a pixel is followed immediately by axiiv=0, pixel_valid and packet_done assert on the same cycle.
- A new packet can start on the cycle after the packet_done/frag_err cycle. There is no minimum inter-packet gap beyond one cycle of axiiv=0.
- Reset mid-packet: all state is cleared immediately. No pixel_valid, packet_done or frag_err is issued for the aborted packet.
- There is no backpressure. The BRAM write port must accept every strobe.

Test Plan:
- Address 0x000005 (dibits 01,01,00×10), then pixel 0xE4 (dibits 00,01,10,11), then axiiv=0 -> one pixel_valid with pixel_out=0xE4 and pixel_addr_out=0x000005; packet_done on the same cycle as pixel_valid.
- Address 0x000000, then four 0xE4 pixels back-to-back -> pixel_valid every 4 cycles at addresses 0,1,2,3, each with data 0xE4; single packet_done.
- Address 0xFFFFFF (12×11), then two pixels 0x1B and 0xFF -> writes at 0xFFFFFF and then 0x000000; no frag_err.
- axiiv drops after 5 address dibits -> frag_err=1 for 1 cycle, no pixel_valid. The next clean packet with address 0x000010 and pixel 0xAA writes 0xAA to 0x000010.
- axiiv drops after 2 dibits of the second pixel -> first pixel written, frag_err pulse, no second write, no packet_done.
- rst driven low asynchronously between clock edges mid-pixel -> all outputs 0 immediately. After release, a fresh packet decodes correctly from IDLE.
